// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem, redirect and decode handshake signals of the fetch stage
interface fetch_unit_if #(
    parameter int N       = 64,
    parameter int IMEM_AW = 6
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_q;
    logic               redirect_valid;
    logic [N-1:0]       redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic [N-1:0]       instr_pc;
    modport master (
        output imem_addr, instr_valid, instr, instr_pc,
        input  imem_q, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_addr, instr_valid, instr, instr_pc,
        output imem_q, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 fetch PC, imem addressing and DEPTH-entry instruction buffer
module fetch_unit #(
    parameter int N       = 64,
    parameter int IMEM_AW = 6,
    parameter int DEPTH   = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  pc_q, pc_d;
    logic [N-1:0]  bpc_q [DEPTH];
    logic [31:0]   bins_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // redirect wins: buffer flushed, no push, target PC word-aligned
    always_comb begin
        pop    = bus.instr_valid & bus.instr_ready;
        push   = ~bus.redirect_valid & (cnt_q < CW'(DEPTH) | pop);
        pc_d   = bus.redirect_valid ? bus.redirect_pc & ~N'(3) : push ? pc_q + N'(4) : pc_q;
        rptr_d = bus.redirect_valid ? '0 : pop ? inc(rptr_q) : rptr_q;
        wptr_d = bus.redirect_valid ? '0 : push ? inc(wptr_q) : wptr_q;
        cnt_d  = bus.redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bpc_q[i]  <= '0;
                bins_q[i] <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            if (push) begin
                bpc_q[wptr_q]  <= pc_q;
                bins_q[wptr_q] <= bus.imem_q;
            end
        end
    end

    assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
    assign bus.instr_valid = cnt_q != '0;
    assign bus.instr       = bins_q[rptr_q];
    assign bus.instr_pc    = bpc_q[rptr_q];
endmodule
